// File: rtl/serial_rx_word_pkg.sv
// ============================================================================
// Module   : serial_rx_word_pkg
// Brief    : Shared serial-link constants and receiver state type.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package serial_rx_word_pkg;

    localparam int WORD_W = 27;
    localparam int CNT_W  = $clog2(WORD_W);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RECV = 1'b1
    } rx_state_t;

endpackage : serial_rx_word_pkg

`default_nettype wire

// File: rtl/serial_rx_word.sv
// ============================================================================
// Module   : serial_rx_word
// Brief    : Enable-qualified serial receiver, MSB-first frames to WIDTH-bit words.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_rx_word
    import serial_rx_word_pkg::*;
#(
    parameter int WIDTH = WORD_W
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             data_i,
    input  logic             ena_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o,
    output logic             busy_o,
    output logic             err_o
);

    // Counter keeps at least one bit so a WIDTH=1 build still elaborates.
    localparam int             CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    rx_state_t        state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] w_word;

    generate
        if (WIDTH > 1) begin : g_wide
            assign w_word = {shreg_q[WIDTH-2:0], data_i};
        end else begin : g_narrow
            assign w_word = data_i;
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        data_d  = data_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (ena_i) begin
                    shreg_d = w_word;
                    if (WIDTH == 1) begin
                        data_d  = w_word;
                        valid_d = 1'b1;
                    end else begin
                        cnt_d   = CW'(1);
                        state_d = RECV;
                    end
                end
            end
            RECV: begin
                if (ena_i) begin
                    shreg_d = w_word;
                    if (cnt_q == LAST) begin
                        data_d  = w_word;
                        valid_d = 1'b1;
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end else begin
                    // Enable dropped mid-frame: abandon the partial word.
                    err_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shreg_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;
    assign err_o   = err_q;
    assign busy_o  = (state_q == RECV);

endmodule : serial_rx_word

`default_nettype wire

// File: tb/tb_serial_rx_word.sv
// ============================================================================
// Module   : tb_serial_rx_word
// Brief    : Directed self-checking bench for serial_rx_word.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_rx_word;

    localparam int W = 27;

    logic         clk_i;
    logic         rst_i;
    logic         data_i;
    logic         ena_i;
    logic [W-1:0] data_o;
    logic         valid_o;
    logic         busy_o;
    logic         err_o;

    int           vectors;
    int           miscompares;
    logic         chk_en;
    logic         exp_v, exp_e, exp_b;
    logic [W-1:0] exp_d;

    serial_rx_word #(.WIDTH(W)) dut (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .data_i (data_i),
        .ena_i  (ena_i),
        .data_o (data_o),
        .valid_o(valid_o),
        .busy_o (busy_o),
        .err_o  (err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, expv, $time);
        end
    endtask

    // Checks the outputs produced by the previous edge, then drives the next
    // inputs and records what the following edge must produce.
    task automatic cyc(input logic r, input logic d, input logic e,
                       input logic nv, input logic ne, input logic nb,
                       input logic [W-1:0] nd);
        @(negedge clk_i);
        if (chk_en) begin
            chk("valid_o", W'(valid_o), W'(exp_v));
            chk("err_o",   W'(err_o),   W'(exp_e));
            chk("busy_o",  W'(busy_o),  W'(exp_b));
            chk("data_o",  data_o,      exp_d);
        end
        rst_i  = r;
        data_i = d;
        ena_i  = e;
        exp_v  = nv;
        exp_e  = ne;
        exp_b  = nb;
        exp_d  = nd;
        chk_en = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            cyc(1'b0, 1'($urandom), 1'b0, 1'b0, 1'b0, 1'b0, exp_d);
    endtask

    task automatic send_bits(input logic [W-1:0] w, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            if (i == W - 1)
                cyc(1'b0, w[W-1-i], 1'b1, 1'b1, 1'b0, 1'b0, w);
            else
                cyc(1'b0, w[W-1-i], 1'b1, 1'b0, 1'b0, 1'b1, exp_d);
        end
    endtask

    initial begin
        logic [W-1:0] w;
        clk_i       = 1'b0;
        rst_i       = 1'b1;
        data_i      = 1'b0;
        ena_i       = 1'b0;
        vectors     = 0;
        miscompares = 0;
        chk_en      = 1'b0;
        exp_v       = 1'b0;
        exp_e       = 1'b0;
        exp_b       = 1'b0;
        exp_d       = '0;

        // Reset held with live traffic: everything stays zero.
        for (int i = 0; i < 3; i++)
            cyc(1'b1, 1'(i), 1'b1, 1'b0, 1'b0, 1'b0, '0);
        idle(2);

        // Single frame.
        send_bits(27'h5A5A5A5, W);
        idle(2);

        // Back-to-back frames with no gap.
        send_bits(27'h7FFFFFF, W);
        send_bits(27'h0000001, W);
        idle(2);

        // Abort after 10 bits, then a clean frame.
        send_bits(27'h1234567, 10);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, exp_d);
        idle(2);
        send_bits(27'h1234567, W);
        idle(1);

        // Serializer-style traffic with random idle gaps.
        for (int k = 0; k < 100; k++) begin
            w = W'($urandom);
            send_bits(w, W);
            idle($urandom_range(0, 5));
        end
        idle(1);

        // Reset mid-frame: no error, outputs cleared, next frame clean.
        send_bits(27'h3C3C3C3, 13);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, '0);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
        send_bits(27'h2AAAAAA, W);
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_serial_rx_word

`default_nettype wire

// File: doc/serial_rx_word.md
# serial_rx_word

Serial-to-parallel receiver for the one-bit, enable-qualified link driven by the team's word serializer (`start_i`/`data_i[26:0]` in; `data_o`/`ena_o` out). It samples the serial bit stream on every cycle where the enable is high and reassembles MSB-first frames into WIDTH-bit words. It presents each completed word with a one-cycle valid strobe. It sits at the far end of the serial link, in loopback benches and in downstream consumers of the serialized word.

## Interface
- `WIDTH`, default 27: bits per frame; must match the serializer word width.
- `clk_i`, input, 1: sole clock; all state updates on its rising edge.
- `rst_i`, input, 1: reset, synchronous, active-high.
- `data_i`, input, 1: serial bit; connects to serializer `data_o`.
- `ena_i`, input, 1: bit-qualifier; connects to serializer `ena_o`; high = `data_i` carries a valid bit this cycle.
- `data_o`, output, WIDTH: last completed word, bit WIDTH-1 = first bit received.
- `valid_o`, output, 1: one-cycle strobe; `data_o` holds a newly completed word.
- `busy_o`, output, 1: high while a frame is partially received.
- `err_o`, output, 1: one-cycle strobe; a frame was aborted (enable dropped mid-frame).

## Operation
- Bit order: MSB first. Each accepted bit is shifted in as `shreg <= {shreg[WIDTH-2:0], data_i}`.
- The bit counter `cnt` has width `$clog2(WIDTH)` and runs 0..WIDTH-1.
- FSM, two states:
  - IDLE, with cnt=0.
    - `ena_i`=1: capture the bit, cnt←1, go to RECV.
    - Special case WIDTH=1: complete immediately and stay in IDLE.
  - RECV.
    - `ena_i`=1 and cnt<WIDTH-1: capture the bit, cnt++.
    - `ena_i`=1 and cnt==WIDTH-1: capture the final bit, `data_o`←{shreg[WIDTH-2:0], data_i}, `valid_o`←1, cnt←0, go to IDLE.
    - `ena_i`=0: abort. `err_o`←1, cnt←0, go to IDLE. `shreg` contents are don't-care; `data_o` is unchanged.
- `busy_o` = (state==RECV), registered.
- `data_o` holds the last good word indefinitely. It changes only on frame completion or reset.
- Back-to-back frames: `ena_i` stays high across a frame boundary. The bit after the WIDTH-th bit starts the next frame in the very next cycle, with no gap required and no bit lost.
- Idle gaps of any length between frames are legal and silent: no `err_o` while in IDLE.
- `start_i` of the serializer is not observed. Framing is defined solely by `ena_i` run length.

## Timing
- Reset, synchronous, wins over all other inputs. On reset: `data_o`=0, `valid_o`=0, `busy_o`=0, `err_o`=0, cnt=0, state=IDLE, `shreg`=0.
- Reset mid-frame discards the partial frame with no `err_o`. The next `ena_i` high after reset release starts a new frame.
- Latency: if the last bit is presented with `ena_i` high in cycle N, then `data_o` and `valid_o` are valid in cycle N+1.
- `valid_o` is high for exactly one cycle per completed frame.
- Abort: if `ena_i` is low in cycle N while in RECV, then `err_o` is high in cycle N+1 for one cycle, and `busy_o` is low from N+1.
- `valid_o` and `err_o` are never high in the same cycle.
- All outputs are registered; there is no combinational path from inputs to outputs.
- Throughput: one word per WIDTH cycles at full rate.

## Structure
- Shared link package holds:
  - `WORD_W` = 27, used as the default for WIDTH here and in the serializer.
  - `CNT_W` = `$clog2(WORD_W)`.
  - typedef `rx_state_t` {IDLE, RECV}.
- A single module with no sub-modules. The shift register, counter and FSM are small enough to sit in one always_ff block plus next-state logic.

## Test plan
- Reset check: assert `rst_i` for 3 cycles with `ena_i`=1 toggling data → all outputs 0 throughout and after release; no `valid_o`/`err_o`.
- Single frame: shift 27'h5A5A5A5 MSB-first with `ena_i` high for 27 cycles → `valid_o` for one cycle, one cycle after the last bit, with `data_o`=27'h5A5A5A5; `busy_o` high for cycles 2..27 of the frame.
- Back-to-back: 27'h7FFFFFF then 27'h0000001 with `ena_i` continuously high for 54 cycles → two `valid_o` strobes exactly 27 cycles apart, carrying the correct words in order.
- Abort: send 10 bits of 27'h1234567, then drop `ena_i` → `err_o` pulse one cycle later; `data_o` keeps its previous value. A subsequent full frame of 27'h1234567 → `valid_o` with `data_o`=27'h1234567.
- Loopback with serializer: 100 random 27-bit words with random idle gaps of 0..5 cycles → every received word matches the transmitted word in order; `err_o` never fires.
- Reset mid-frame: assert `rst_i` after 13 bits → no `err_o`, outputs cleared. A fresh frame of 27'h2AAAAAA → received correctly.
